alarm_ring_ctrl: RTL and testbench
==================================

Name: alarm_ring_ctrl

Overview:
- Sequences the alarm sounder once the alarm-time comparator reports a match.
- Owns ring timeout, snooze and stop behaviour, plus the 1 Hz beep cadence.
- Sits between the alarm enable/match logic and the buzzer/piezo driver.
- Driven by the watch's one-second tick and two front-panel buttons.

Parameters:
- RING_SEC, 60, seconds of ringing before auto-stop (2..511)
- SNOOZE_SEC, 300, seconds of silence per snooze (2..511)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (0..3)

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RESET  input  1  asynchronous, active-high reset
- ALR_EN  input  1  alarm armed (on/off state), level
- MATCH  input  1  alarm time equals current time, level (high for the whole matching minute)
- SEC_TICK  input  1  one-CLK pulse once per second
- SNZ_BTN  input  1  snooze button, synchronised level
- STOP_BTN  input  1  stop button, synchronised level
- BUZZ  output  1  buzzer gate, registered
- RINGING  output  1  state is RING, registered
- SNOOZING  output  1  state is SNOOZE, registered
- SNZ_CNT  output  2  snoozes used in current event, registered

Behaviour:
- Reset (async, RESET=1): state IDLE; BUZZ, RINGING, SNOOZING=0; SNZ_CNT=0; sec_cnt=0; beep=0.
- Reset also clears the MATCH_LAST, SNZ_LAST and STOP_LAST edge registers to 0.
- Edge detect: each input is registered into *_LAST every CLK.
  - match_rise = MATCH & ~MATCH_LAST
  - snz_rise = SNZ_BTN & ~SNZ_LAST
  - stop_rise = STOP_BTN & ~STOP_LAST
  - A held button acts once.
- States: IDLE, RING, SNOOZE. sec_cnt is 9 bits.
- Priority per cycle, highest first: ALR_EN=0, stop_rise, snz_rise, tick/timeout.
- ALR_EN=0 in any state: next state IDLE, SNZ_CNT=0, BUZZ=0.
- IDLE:
  - Goes to RING on match_rise & ALR_EN.
  - On that transition: sec_cnt=0, SNZ_CNT=0, beep=1.
  - Outputs reflect RING on the cycle after the edge where match_rise was seen (1-cycle latency).
  - No retrigger while MATCH stays high after a stop: a rising edge is required.
- RING:
  - BUZZ = beep. beep toggles on each SEC_TICK, giving a 1 s on / 1 s off pattern starting with "on".
  - stop_rise: go to IDLE.
  - snz_rise with SNZ_CNT<MAX_SNOOZE: go to SNOOZE, SNZ_CNT+1, sec_cnt=0, BUZZ=0.
  - snz_rise with SNZ_CNT==MAX_SNOOZE: ignored, keep ringing.
  - SEC_TICK: sec_cnt+1. If SEC_TICK arrives with sec_cnt==RING_SEC-1: go to IDLE (auto-stop).
- SNOOZE:
  - BUZZ=0.
  - SEC_TICK: sec_cnt+1. If SEC_TICK arrives with sec_cnt==SNOOZE_SEC-1: go to RING, sec_cnt=0, beep=1, SNZ_CNT held.
  - stop_rise: go to IDLE.
  - snz_rise: ignored.
  - MATCH is ignored in SNOOZE and RING.
- Leaving to IDLE: SNZ_CNT is held until the next RING entry from IDLE or until ALR_EN=0, so the display can show snoozes used.
- Simultaneous events:
  - stop_rise with snz_rise: stop wins.
  - stop_rise with the timeout tick: IDLE.
  - snz_rise with the timeout tick in RING: snooze wins, if allowed.
- Reset mid-ring or mid-snooze returns everything to reset values immediately (asynchronous).
- No counter wraps: sec_cnt is always cleared on state entry and bounded by the parameters.

Test Plan:
1. Ring and auto-stop with RING_SEC=4, SEC_TICK every 8 CLK. Stimulus: ALR_EN=1, raise MATCH. Required:
   - RINGING=1 one cycle later.
   - BUZZ pattern 1,0,1,0 across ticks.
   - IDLE after the 4th tick.
   - Holding MATCH high afterwards causes no re-ring.
2. Snooze cycle with SNOOZE_SEC=3. Stimulus: pulse SNZ_BTN during RING. Required:
   - SNOOZING=1, BUZZ=0, SNZ_CNT=1.
   - After the 3rd tick: RINGING=1, BUZZ=1.
3. Snooze limit with MAX_SNOOZE=2. Stimulus: snooze twice, then a third SNZ_BTN in RING. Required: stays RING, SNZ_CNT=2.
4. Held button. Stimulus: SNZ_BTN held high for 20 cycles. Required: exactly one snooze (SNZ_CNT=1). Then STOP_BTN and SNZ_BTN rise in the same cycle during RING. Required: IDLE.
5. Disable and reset. Stimulus: drop ALR_EN during SNOOZE. Required: IDLE, SNZ_CNT=0 next cycle. Then assert RESET asynchronously mid-RING between clock edges. Required: BUZZ, RINGING = 0 immediately.
6. Alarm disarmed. Stimulus: MATCH rises with ALR_EN=0. Required: stays IDLE, BUZZ=0 throughout.

Source files
------------

// File: rtl/alarm_ring_ctrl.sv
// Alarm sounder sequencer: rings on an alarm-time match, handles snooze/stop/timeout
// and gates the buzzer with a 1 s on / 1 s off cadence.
module alarm_ring_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ALR_EN,
    input  logic       MATCH,
    input  logic       SEC_TICK,
    input  logic       SNZ_BTN,
    input  logic       STOP_BTN,
    output logic       BUZZ,
    output logic       RINGING,
    output logic       SNOOZING,
    output logic [1:0] SNZ_CNT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam logic [8:0] RING_LAST   = 9'(RING_SEC - 1);
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SEC - 1);
    localparam logic [1:0] SNZ_MAX     = 2'(MAX_SNOOZE);

    state_t     state_r, state_s;
    logic [8:0] sec_cnt_r, sec_cnt_s;
    logic       beep_r, beep_s;
    logic [1:0] snz_cnt_r, snz_cnt_s;
    logic       match_last_r, snz_last_r, stop_last_r;
    logic       buzz_r, ringing_r, snoozing_r;
    logic       match_rise_s, snz_rise_s, stop_rise_s;

    assign match_rise_s = MATCH & ~match_last_r;
    assign snz_rise_s   = SNZ_BTN & ~snz_last_r;
    assign stop_rise_s  = STOP_BTN & ~stop_last_r;

    // Next-state logic; disarm overrides everything, then stop, snooze, tick.
    always_comb begin
        state_s   = state_r;
        sec_cnt_s = sec_cnt_r;
        beep_s    = beep_r;
        snz_cnt_s = snz_cnt_r;
        if (!ALR_EN) begin
            state_s   = IDLE;
            sec_cnt_s = 9'd0;
            beep_s    = 1'b0;
            snz_cnt_s = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (match_rise_s) begin
                        state_s   = RING;
                        sec_cnt_s = 9'd0;
                        snz_cnt_s = 2'd0;
                        beep_s    = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RING: begin
                    if (stop_rise_s) begin
                        state_s = IDLE;
                    end else if (snz_rise_s && (snz_cnt_r < SNZ_MAX)) begin
                        state_s   = SNOOZE;
                        snz_cnt_s = snz_cnt_r + 2'd1;
                        sec_cnt_s = 9'd0;
                    end else if (SEC_TICK) begin
                        if (sec_cnt_r == RING_LAST) begin
                            state_s = IDLE;
                        end else begin
                            sec_cnt_s = sec_cnt_r + 9'd1;
                            beep_s    = ~beep_r;
                        end
                    end else begin
                        state_s = RING;
                    end
                end
                SNOOZE: begin
                    if (stop_rise_s) begin
                        state_s = IDLE;
                    end else if (SEC_TICK) begin
                        if (sec_cnt_r == SNOOZE_LAST) begin
                            state_s   = RING;
                            sec_cnt_s = 9'd0;
                            beep_s    = 1'b1;
                        end else begin
                            sec_cnt_s = sec_cnt_r + 9'd1;
                        end
                    end else begin
                        state_s = SNOOZE;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    sec_cnt_s = 9'd0;
                    beep_s    = 1'b0;
                    snz_cnt_s = 2'd0;
                end
            endcase
        end
    end

    // State, counters, edge-detect history and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= IDLE;
            sec_cnt_r    <= 9'd0;
            beep_r       <= 1'b0;
            snz_cnt_r    <= 2'd0;
            match_last_r <= 1'b0;
            snz_last_r   <= 1'b0;
            stop_last_r  <= 1'b0;
            buzz_r       <= 1'b0;
            ringing_r    <= 1'b0;
            snoozing_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            sec_cnt_r    <= sec_cnt_s;
            beep_r       <= beep_s;
            snz_cnt_r    <= snz_cnt_s;
            match_last_r <= MATCH;
            snz_last_r   <= SNZ_BTN;
            stop_last_r  <= STOP_BTN;
            // Outputs are decoded from the next state so they track state_r exactly.
            buzz_r       <= (state_s == RING) & beep_s;
            ringing_r    <= (state_s == RING);
            snoozing_r   <= (state_s == SNOOZE);
        end
    end

    assign BUZZ     = buzz_r;
    assign RINGING  = ringing_r;
    assign SNOOZING = snoozing_r;
    assign SNZ_CNT  = snz_cnt_r;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_alarm_ring_ctrl;

    logic       CLK;
    logic       RESET;
    logic       ALR_EN;
    logic       MATCH;
    logic       SEC_TICK;
    logic       SNZ_BTN;
    logic       STOP_BTN;
    logic       BUZZ;
    logic       RINGING;
    logic       SNOOZING;
    logic [1:0] SNZ_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] exp_q[$];
    string      name_q[$];

    alarm_ring_ctrl #(
        .RING_SEC  (4),
        .SNOOZE_SEC(3),
        .MAX_SNOOZE(2)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ALR_EN  (ALR_EN),
        .MATCH   (MATCH),
        .SEC_TICK(SEC_TICK),
        .SNZ_BTN (SNZ_BTN),
        .STOP_BTN(STOP_BTN),
        .BUZZ    (BUZZ),
        .RINGING (RINGING),
        .SNOOZING(SNOOZING),
        .SNZ_CNT (SNZ_CNT)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Monitor: compare every queued expectation against the outputs mid-cycle.
    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            logic [4:0] e;
            string      nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if ({BUZZ, RINGING, SNOOZING, SNZ_CNT} !== e) begin
                n_fail++;
                $display("FAIL %s: got buzz=%0b ringing=%0b snoozing=%0b snz_cnt=%0d, expected buzz=%0b ringing=%0b snoozing=%0b snz_cnt=%0d",
                         nm, BUZZ, RINGING, SNOOZING, SNZ_CNT, e[4], e[3], e[2], e[1:0]);
            end
        end
    end

    // Watchdog against a hung simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Seven quiet cycles then a one-cycle SEC_TICK: one tick every 8 CLK.
    task automatic tick();
        steps(7);
        SEC_TICK = 1'b1;
        step();
        SEC_TICK = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic b, input logic r,
                              input logic s, input logic [1:0] c);
        exp_q.push_back({b, r, s, c});
        name_q.push_back(nm);
    endtask

    // Main stimulus sequence.
    initial begin
        RESET    = 1'b1;
        ALR_EN   = 1'b0;
        MATCH    = 1'b0;
        SEC_TICK = 1'b0;
        SNZ_BTN  = 1'b0;
        STOP_BTN = 1'b0;
        steps(2);
        RESET = 1'b0;
        expect_out("reset_state", 1'b0, 1'b0, 1'b0, 2'd0);
        step();

        // 1: ring, cadence, auto-stop, no retrigger while MATCH held
        ALR_EN = 1'b1;
        step();
        MATCH = 1'b1;
        expect_out("pre_edge_idle", 1'b0, 1'b0, 1'b0, 2'd0);
        step();
        expect_out("ring_entry", 1'b1, 1'b1, 1'b0, 2'd0);
        n_checks++;
        if (RINGING !== 1'b1 || BUZZ !== 1'b1) begin
            n_fail++;
            $display("FAIL ring_entry_now: got ringing=%0b buzz=%0b, expected ringing=1 buzz=1", RINGING, BUZZ);
        end
        tick();
        expect_out("beep_tick1", 1'b0, 1'b1, 1'b0, 2'd0);
        tick();
        expect_out("beep_tick2", 1'b1, 1'b1, 1'b0, 2'd0);
        tick();
        expect_out("beep_tick3", 1'b0, 1'b1, 1'b0, 2'd0);
        tick();
        expect_out("auto_stop", 1'b0, 1'b0, 1'b0, 2'd0);
        n_checks++;
        if (RINGING !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_stop_now: got ringing=%0b, expected ringing=0", RINGING);
        end
        tick();
        tick();
        expect_out("no_retrigger", 1'b0, 1'b0, 1'b0, 2'd0);
        MATCH = 1'b0;
        step();

        // 2: snooze then re-ring after SNOOZE_SEC ticks
        MATCH = 1'b1;
        step();
        MATCH = 1'b0;
        expect_out("ring2_entry", 1'b1, 1'b1, 1'b0, 2'd0);
        steps(2);
        SNZ_BTN = 1'b1;
        step();
        SNZ_BTN = 1'b0;
        expect_out("snooze1", 1'b0, 1'b0, 1'b1, 2'd1);
        n_checks++;
        if (SNOOZING !== 1'b1 || SNZ_CNT !== 2'd1) begin
            n_fail++;
            $display("FAIL snooze1_now: got snoozing=%0b snz_cnt=%0d, expected snoozing=1 snz_cnt=1", SNOOZING, SNZ_CNT);
        end
        tick();
        expect_out("snooze1_tick1", 1'b0, 1'b0, 1'b1, 2'd1);
        tick();
        tick();
        expect_out("snooze1_rering", 1'b1, 1'b1, 1'b0, 2'd1);

        // 3: snooze limit
        SNZ_BTN = 1'b1;
        step();
        SNZ_BTN = 1'b0;
        expect_out("snooze2", 1'b0, 1'b0, 1'b1, 2'd2);
        tick();
        tick();
        tick();
        expect_out("snooze2_rering", 1'b1, 1'b1, 1'b0, 2'd2);
        SNZ_BTN = 1'b1;
        step();
        SNZ_BTN = 1'b0;
        expect_out("snooze_limit", 1'b1, 1'b1, 1'b0, 2'd2);
        step();
        STOP_BTN = 1'b1;
        step();
        STOP_BTN = 1'b0;
        expect_out("stop_holds_cnt", 1'b0, 1'b0, 1'b0, 2'd2);
        step();

        // 4: held snooze acts once; stop beats snooze in the same cycle
        MATCH = 1'b1;
        step();
        MATCH = 1'b0;
        expect_out("ring4_entry", 1'b1, 1'b1, 1'b0, 2'd0);
        SNZ_BTN = 1'b1;
        step();
        expect_out("held_snz_first", 1'b0, 1'b0, 1'b1, 2'd1);
        steps(19);
        expect_out("held_snz_once", 1'b0, 1'b0, 1'b1, 2'd1);
        SNZ_BTN = 1'b0;
        step();
        tick();
        tick();
        tick();
        expect_out("ring4_rering", 1'b1, 1'b1, 1'b0, 2'd1);
        STOP_BTN = 1'b1;
        SNZ_BTN  = 1'b1;
        step();
        expect_out("stop_wins", 1'b0, 1'b0, 1'b0, 2'd1);
        n_checks++;
        if (RINGING !== 1'b0 || SNOOZING !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_wins_now: got ringing=%0b snoozing=%0b, expected ringing=0 snoozing=0", RINGING, SNOOZING);
        end
        STOP_BTN = 1'b0;
        SNZ_BTN  = 1'b0;
        step();

        // 5: disarm during snooze, then async reset mid-ring
        MATCH = 1'b1;
        step();
        MATCH = 1'b0;
        expect_out("ring5_entry", 1'b1, 1'b1, 1'b0, 2'd0);
        SNZ_BTN = 1'b1;
        step();
        SNZ_BTN = 1'b0;
        expect_out("snooze5", 1'b0, 1'b0, 1'b1, 2'd1);
        step();
        ALR_EN = 1'b0;
        step();
        expect_out("disarm_clears", 1'b0, 1'b0, 1'b0, 2'd0);
        ALR_EN = 1'b1;
        step();
        MATCH = 1'b1;
        step();
        MATCH = 1'b0;
        expect_out("ring5b_entry", 1'b1, 1'b1, 1'b0, 2'd0);
        step();
        #1;
        RESET = 1'b1;
        #1;
        n_checks++;
        if (BUZZ !== 1'b0 || RINGING !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_now: got buzz=%0b ringing=%0b, expected buzz=0 ringing=0", BUZZ, RINGING);
        end
        expect_out("async_reset", 1'b0, 1'b0, 1'b0, 2'd0);
        steps(2);
        RESET = 1'b0;
        step();
        expect_out("post_reset_idle", 1'b0, 1'b0, 1'b0, 2'd0);

        // 6: MATCH while disarmed never rings, nor when arming with MATCH already high
        ALR_EN = 1'b0;
        step();
        MATCH = 1'b1;
        step();
        expect_out("disarmed_match", 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        expect_out("disarmed_tick", 1'b0, 1'b0, 1'b0, 2'd0);
        ALR_EN = 1'b1;
        step();
        step();
        expect_out("arm_level_match", 1'b0, 1'b0, 1'b0, 2'd0);
        MATCH = 1'b0;
        steps(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
